uart_rx_param: RTL and testbench

Parametrised UART receiver: samples an asynchronous serial line with a programmable oversampling tick and deserialises LSB-first frames of DATA_BITS with optional even/odd parity and 1 or 2 stop bits. Presents each received word through a valid/ack holding register and flags parity, framing and overrun errors. It sits between the pad-level rx line and the consuming register/FIFO logic, and replaces the fixed 8-bit receiver.

---
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with valid/ack holding
//            register and parity / framing / overrun error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int c_TW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS + 1);
  localparam logic [c_TW-1:0] c_TICK_HALF = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TW-1:0] c_TICK_FULL = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP1  = 3'd4;
  localparam logic [2:0] c_STOP2  = 3'd5;

  logic [2:0]           r_state, w_next_state;
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]           r_fill;
  logic                 r_armed;
  logic [DIV_WIDTH-1:0] r_div_cnt, r_baud;
  logic [c_TW-1:0]      r_tick_cnt;
  logic [c_BW-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data_out;
  logic [1:0]           r_par_mode;
  logic                 r_stop2, r_par_flag, r_frame_flag;
  logic                 r_valid, r_perr, r_ferr, r_ovr;
  logic                 w_start_det, w_tick, w_sample, w_par_en, w_par_bad;
  logic                 w_busy, w_complete, w_frame_now;

  // r_armed waits until the synchroniser holds real line data and sees it high,
  // so neither the preset values nor a line stuck low can fake a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_fill    <= {r_fill[0], 1'b1};
      r_armed   <= r_armed | (r_fill[1] & r_rx_sync);
    end
  end

  assign w_start_det = (r_state == c_IDLE) && r_armed && r_rx_prev && !r_rx_sync;
  assign w_tick      = (r_state != c_IDLE) && (r_div_cnt == r_baud);
  assign w_sample    = w_tick && (r_tick_cnt == ((r_state == c_START) ? c_TICK_HALF : c_TICK_FULL));
  assign w_par_en    = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_par_bad   = ((^r_shift) ^ r_rx_sync) != (r_par_mode == 2'b10);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (w_start_det) w_next_state = c_START;
      c_START:  if (w_sample) w_next_state = r_rx_sync ? c_IDLE : c_DATA;
      c_DATA:   if (w_sample && (r_bit_cnt == c_BIT_LAST))
                  w_next_state = w_par_en ? c_PARITY : c_STOP1;
      c_PARITY: if (w_sample) w_next_state = c_STOP1;
      c_STOP1:  if (w_sample) w_next_state = r_stop2 ? c_STOP2 : c_IDLE;
      c_STOP2:  if (w_sample) w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != c_IDLE);
    w_complete  = w_sample && (((r_state == c_STOP1) && !r_stop2) || (r_state == c_STOP2));
    w_frame_now = r_frame_flag | !r_rx_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt    <= '0;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_baud       <= '0;
      r_par_mode   <= 2'b00;
      r_stop2      <= 1'b0;
      r_par_flag   <= 1'b0;
      r_frame_flag <= 1'b0;
    end else if (w_start_det) begin
      r_div_cnt    <= '0;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_baud       <= baud_div;
      r_par_mode   <= parity_mode;
      r_stop2      <= stop_bits;
      r_par_flag   <= 1'b0;
      r_frame_flag <= 1'b0;
    end else if (r_state == c_IDLE) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_WIDTH'(1);
      if (w_tick) r_tick_cnt <= w_sample ? '0 : r_tick_cnt + c_TW'(1);
      if (w_sample) begin
        case (r_state)
          c_DATA: begin
            r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + c_BW'(1);
          end
          c_PARITY: r_par_flag <= w_par_bad;
          c_STOP1:  r_frame_flag <= w_frame_now;
          default:  ;
        endcase
      end
    end
  end

  // A completion coinciding with an ack is a clean hand-over, not an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (w_complete) begin
      r_data_out <= r_shift;
      r_valid    <= 1'b1;
      r_perr     <= r_par_flag;
      r_ferr     <= w_frame_now;
      if (r_valid) r_ovr <= !data_ack;
    end else if (data_ack && r_valid) begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;
  assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// Testbench for uart_rx_param: directed frames, scoreboard of expected words,
// immediate-assertion checks.
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic        rx = 1'b1;
  logic        data_ack = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid, parity_err, frame_err, overrun_err, busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;
  exp_t sb[$];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .rx(rx), .data_ack(data_ack), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int t);
    rx = v;
    repeat (t) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit,
                            input bit two_stop, input bit s2, input int bd);
    int t;
    t = 16 * (bd + 1);
    @(posedge clk);
    #1;
    drive_bit(1'b0, t);
    for (int i = 0; i < 8; i++) drive_bit(d[i], t);
    if (has_par) drive_bit(pbit, t);
    drive_bit(1'b1, t);
    if (two_stop) drive_bit(s2, t);
    drive_bit(1'b1, t);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(data_valid), 32'd1);
      chk({tag, "_data"}, 32'(data_out), 32'(e.d));
      chk({tag, "_perr"}, 32'(parity_err), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(frame_err), 32'(e.fe));
      chk({tag, "_ovr"}, 32'(overrun_err), 32'(e.ov));
    end
  endtask

  task automatic ack_and_check(input string tag);
    @(posedge clk);
    #1 data_ack = 1'b1;
    @(posedge clk);
    #1 data_ack = 1'b0;
    chk({tag, "_ack_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_ack_flags"}, 32'({parity_err, frame_err, overrun_err}), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_flags"}, 32'({data_valid, parity_err, frame_err, overrun_err}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Basic 8N1 frame with latency measurement
    expect_word(8'hA5, 1'b0, 1'b0, 1'b0);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        @(posedge clk);
        #1;
        while (!data_valid && lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
        end
      end
    join
    chk("latency_in_window", 32'(lat >= 154 && lat <= 156), 32'd1);
    check_sb("a5");
    ack_and_check("a5");

    // Parity variants on 0x03 (even number of ones)
    parity_mode = 2'b01;
    expect_word(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check_sb("even_ok");
    ack_and_check("even_ok");
    expect_word(8'h03, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    check_sb("even_bad");
    ack_and_check("even_bad");
    parity_mode = 2'b10;
    expect_word(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    check_sb("odd_ok");
    ack_and_check("odd_ok");
    parity_mode = 2'b00;

    // Two stop bits, second one low, then a clean frame
    stop_bits = 1'b1;
    expect_word(8'h5A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_sb("stop2_low");
    ack_and_check("stop2_low");
    expect_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check_sb("stop2_ok");
    ack_and_check("stop2_ok");
    stop_bits = 1'b0;

    // Overrun, then a completion coinciding with ack
    expect_word(8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_sb("ovr_first");
    expect_word(8'h34, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_sb("ovr_second");
    expect_word(8'h56, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
      end
    join
    check_sb("ack_on_complete");
    ack_and_check("ack_on_complete");

    // Glitch: 4 clocks low is a false start
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_busy_during", 32'(busy), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_busy_after", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(data_valid), 32'd0);

    // Slower baud: 64 clocks per bit
    baud_div = 16'd3;
    expect_word(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    baud_div = 16'd0;
    check_sb("baud3");

    // Reset mid-frame while a word is still held
    fork
      send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #1;
        chk("midframe_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
      end
    join
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_idle_outputs("after_reset");
    expect_word(8'h7E, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_sb("post_reset");
    ack_and_check("post_reset");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
